// File: rtl/vector_list_sequencer.sv
// vector_list_sequencer: walks a display list in a synchronous-read memory and drives the line drawer.
// Latency: 3 cycles fetch/wait/decode per command, +1 issue cycle, so JUMP/DRAW pulses are >=4 cycles apart.
// Backpressure: holds in ISSUE while ready is low. Optional macro VECSEQ_CLIP_EN clamps x/y to XMAX/YMAX.
module vector_list_sequencer #(
  parameter int ADDR_W       = 10,
  parameter int COORD_W      = 12,
  parameter int FRAME_W      = 18,
  parameter int FRAME_CYCLES = 166667,
  parameter int XMAX         = 4095,
  parameter int YMAX         = 4095
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               loop,
  input  logic [ADDR_W-1:0]  list_base,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [31:0]        mem_data,
  input  logic               ready,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               draw,
  output logic               jump,
  output logic               busy,
  output logic               frame_done,
  output logic               overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_ISSUE, S_FRAME_WAIT
  } state_t;

  localparam logic [1:0]         OP_NOP     = 2'b10;
  localparam logic [1:0]         OP_END     = 2'b11;
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_CYCLES - 1);
  localparam logic [COORD_W-1:0] X_LIM      = COORD_W'(XMAX);
  localparam logic [COORD_W-1:0] Y_LIM      = COORD_W'(YMAX);

  state_t              state;
  logic [ADDR_W-1:0]   ptr;
  logic [ADDR_W-1:0]   base;
  logic [31:0]         cmd;
  logic [FRAME_W-1:0]  timer;
  logic [ADDR_W-1:0]   ptr_inc;
  logic                wrap;
  logic [COORD_W-1:0]  cmd_x;
  logic [COORD_W-1:0]  cmd_y;
  logic [COORD_W-1:0]  new_x;
  logic [COORD_W-1:0]  new_y;
  logic                unused_cmd;

  // Wrapping back onto the frame's base means the whole address space was walked without END.
  assign ptr_inc = ptr + ADDR_W'(1);
  assign wrap    = (ptr_inc == base);
  assign cmd_x   = cmd[12 +: COORD_W];
  assign cmd_y   = cmd[0 +: COORD_W];
  assign unused_cmd = ^cmd[29:24];

`ifdef VECSEQ_CLIP_EN
  assign new_x = (cmd_x > X_LIM) ? X_LIM : cmd_x;
  assign new_y = (cmd_y > Y_LIM) ? Y_LIM : cmd_y;
`else
  logic unused_clip;
  assign new_x = cmd_x;
  assign new_y = cmd_y;
  assign unused_clip = ^{X_LIM, Y_LIM};
`endif

  // Sequencer FSM; all outputs registered, pulses default low each cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      ptr        <= '0;
      base       <= '0;
      cmd        <= '0;
      timer      <= '0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      x          <= '0;
      y          <= '0;
      draw       <= 1'b0;
      jump       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      mem_rd     <= 1'b0;
      draw       <= 1'b0;
      jump       <= 1'b0;
      frame_done <= 1'b0;
      if (state != S_IDLE && timer != '1) timer <= timer + FRAME_W'(1);

      case (state)
        S_IDLE: begin
          if (start) begin
            ptr      <= list_base;
            base     <= list_base;
            mem_addr <= list_base;
            mem_rd   <= 1'b1;
            timer    <= '0;
            overrun  <= 1'b0;
            busy     <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_FETCH: state <= S_WAIT;
        S_WAIT: begin
          cmd   <= mem_data;
          state <= S_DECODE;
        end
        S_DECODE: begin
          if (cmd[31:30] == OP_END) begin
            frame_done <= 1'b1;
            if (stop) begin state <= S_IDLE; busy <= 1'b0; end
            else      state <= S_FRAME_WAIT;
          end else if (cmd[31:30] == OP_NOP) begin
            if (wrap) begin
              overrun    <= 1'b1;
              frame_done <= 1'b1;
              if (stop) begin state <= S_IDLE; busy <= 1'b0; end
              else      state <= S_FRAME_WAIT;
            end else if (stop) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              ptr      <= ptr_inc;
              mem_addr <= ptr_inc;
              mem_rd   <= 1'b1;
              state    <= S_FETCH;
            end
          end else begin
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (ready) begin
            x    <= new_x;
            y    <= new_y;
            draw <= cmd[30];
            jump <= ~cmd[30];
            if (stop) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else if (wrap) begin
              overrun    <= 1'b1;
              frame_done <= 1'b1;
              state      <= S_FRAME_WAIT;
            end else begin
              ptr      <= ptr_inc;
              mem_addr <= ptr_inc;
              mem_rd   <= 1'b1;
              state    <= S_FETCH;
            end
          end
        end
        S_FRAME_WAIT: begin
          if (timer >= FRAME_LAST) begin
            if (loop && !stop) begin
              ptr      <= list_base;
              base     <= list_base;
              mem_addr <= list_base;
              mem_rd   <= 1'b1;
              timer    <= '0;
              state    <= S_FETCH;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
